// File: rtl/din_gen_arbiter_pkg.sv
// Shared types and helpers for the DIn round-robin arbiter.
package din_arb_pkg;

  typedef enum logic {IDLE, BURST} din_arb_state_e;

  // Width of a counter/index covering n values, never less than one bit.
  function automatic int clog2_safe(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/din_gen_arbiter_if.sv
// Master-side request bus plus slave DIn channel. The arbiter uses the slave modport,
// and the traffic side (masters and DIn sink) uses the master modport.
interface din_gen_arbiter_if
  import din_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int IDX_W = clog2_safe(NUM_REQ);

  logic [NUM_REQ-1:0]             ReqValid;
  logic [NUM_REQ-1:0][DATA_W-1:0] ReqData;
  logic [NUM_REQ-1:0]             ReqLast;
  logic [NUM_REQ-1:0]             ReqReady;
  logic                           DInValid;
  logic [DATA_W-1:0]              DIn;
  logic                           DInReady;
  logic [IDX_W-1:0]               GrantIdx;
  logic                           Busy;
  logic                           BurstTrunc;

  modport master (
    output ReqValid, ReqData, ReqLast, DInReady,
    input  ReqReady, DInValid, DIn, GrantIdx, Busy, BurstTrunc
  );

  modport slave (
    input  ReqValid, ReqData, ReqLast, DInReady,
    output ReqReady, DInValid, DIn, GrantIdx, Busy, BurstTrunc
  );
endinterface

// File: rtl/din_gen_arbiter_picker.sv
// Round-robin winner select: rotate so ptr+1 sits at bit 0, find the lowest set bit,
// then rotate the index back.
module din_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);
  localparam int SW = IDX_W + 1;

  logic [IDX_W-1:0]     start;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [SW-1:0]        sum;

  always_comb begin
    start = (ptr == IDX_W'(NUM_REQ - 1)) ? '0 : IDX_W'(ptr + 1'b1);
    dbl   = {req, req} >> start;
    rot   = dbl[NUM_REQ-1:0];
    any   = |rot;
    sum   = '0;
    // Descending scan so the lowest set rotated bit is the one that sticks.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) sum = SW'(start) + SW'(k);
    end
    if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
    idx = sum[IDX_W-1:0];
  end
endmodule

// File: rtl/din_gen_arbiter.sv
// Round-robin arbiter: locks one master per burst and muxes it onto the slave DIn channel.
module din_gen_arbiter
  import din_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input logic              Clk,
  input logic              Rst,
  din_gen_arbiter_if.slave bus
);
  localparam int IDX_W = clog2_safe(NUM_REQ);
  localparam int CNT_W = clog2_safe(MAX_BURST);

  din_arb_state_e   state;
  logic [IDX_W-1:0] grant, ptr, pick;
  logic [CNT_W-1:0] cnt;
  logic             trunc, any;
  logic             busy, xfer, last_g, at_limit;

  din_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req (bus.ReqValid),
    .ptr (ptr),
    .any (any),
    .idx (pick)
  );

  assign busy     = (state == BURST);
  assign last_g   = bus.ReqLast[grant];
  assign at_limit = (cnt == CNT_W'(MAX_BURST - 1));
  assign xfer     = bus.DInValid && bus.DInReady;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      ptr   <= IDX_W'(NUM_REQ - 1);
      grant <= '0;
      cnt   <= '0;
      trunc <= 1'b0;
    end else begin
      trunc <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            grant <= pick;
            cnt   <= '0;
            state <= BURST;
          end
        end
        BURST: begin
          if (xfer) begin
            if (last_g || at_limit) begin
              ptr   <= grant;
              cnt   <= '0;
              trunc <= at_limit && !last_g;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data path is a pure mux from the granted master; DIn parks at zero while idle.
  assign bus.DInValid   = busy && bus.ReqValid[grant];
  assign bus.DIn        = busy ? bus.ReqData[grant] : '0;
  assign bus.ReqReady   = busy ? ((NUM_REQ'(1) << grant) & {NUM_REQ{bus.DInReady}}) : '0;
  assign bus.GrantIdx   = grant;
  assign bus.Busy       = busy;
  assign bus.BurstTrunc = trunc;
endmodule

// File: tb/tb_din_gen_arbiter.sv
// Directed vector table plus random traffic for the DIn round-robin arbiter.
module tb_din_gen_arbiter;
  logic Clk = 1'b0;
  logic Rst;

  din_gen_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  din_gen_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic [3:0] v, l;
    logic       rdy;
    logic [7:0] d;
    logic       busy;
    logic [1:0] gi;
    logic       dv;
    logic [7:0] din;
    logic [3:0] rr;
    logic       tr;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [3:0] l,
                              input logic rdy, input logic [7:0] d, input logic busy,
                              input logic [1:0] gi, input logic dv, input logic [7:0] din,
                              input logic [3:0] rr, input logic tr);
    vec_t t;
    t.rst = rst; t.v = v; t.l = l; t.rdy = rdy; t.d = d;
    t.busy = busy; t.gi = gi; t.dv = dv; t.din = din; t.rr = rr; t.tr = tr;
    return t;
  endfunction

  task automatic drive(input logic rst, input logic [3:0] v, input logic [3:0] l,
                       input logic rdy, input logic [7:0] d);
    Rst          = rst;
    bus.ReqValid = v;
    bus.ReqLast  = l;
    bus.DInReady = rdy;
    for (int i = 0; i < 4; i++) bus.ReqData[i] = d + 8'(i * 16);
  endtask

  vec_t tbl[$];

  initial begin
    // master 2 alone, 3-beat burst ending with Last
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 1, 8'h01, 0, 0, 0, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 1, 8'h01, 1, 2, 1, 8'h21, 4'b0100, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 1, 8'h02, 1, 2, 1, 8'h22, 4'b0100, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, 8'h03, 1, 2, 1, 8'h23, 4'b0100, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 0, 2, 0, 8'h00, 4'b0000, 0));
    // all masters, 1-beat bursts: ptr=2 so order 3,0,1,2,3,0 with idle bubbles
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'h05, 0, 2, 0, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'h05, 1, 3, 1, 8'h35, 4'b1000, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'h05, 0, 3, 0, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'h05, 1, 0, 1, 8'h05, 4'b0001, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'h05, 0, 0, 0, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'h05, 1, 1, 1, 8'h15, 4'b0010, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'h05, 0, 1, 0, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'h05, 1, 2, 1, 8'h25, 4'b0100, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'h05, 0, 2, 0, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'h05, 1, 3, 1, 8'h35, 4'b1000, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'h05, 0, 3, 0, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'h05, 1, 0, 1, 8'h05, 4'b0001, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 0, 0, 0, 8'h00, 4'b0000, 0));
    // master 1, 6 beats: truncated after beat 4, re-wins for beats 5-6
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 8'h01, 0, 0, 0, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 8'h01, 1, 1, 1, 8'h11, 4'b0010, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 8'h02, 1, 1, 1, 8'h12, 4'b0010, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 8'h03, 1, 1, 1, 8'h13, 4'b0010, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 8'h04, 1, 1, 1, 8'h14, 4'b0010, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 8'h05, 0, 1, 0, 8'h00, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 8'h05, 1, 1, 1, 8'h15, 4'b0010, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 1, 8'h06, 1, 1, 1, 8'h16, 4'b0010, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 0, 1, 0, 8'h00, 4'b0000, 0));
    // master 3, 4 beats with a 3-cycle DInReady stall after beat 1; count must freeze
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 8'h01, 0, 1, 0, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 8'h01, 1, 3, 1, 8'h31, 4'b1000, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 0, 8'h02, 1, 3, 1, 8'h32, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 0, 8'h02, 1, 3, 1, 8'h32, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 0, 8'h02, 1, 3, 1, 8'h32, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 8'h02, 1, 3, 1, 8'h32, 4'b1000, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 8'h03, 1, 3, 1, 8'h33, 4'b1000, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 8'h04, 1, 3, 1, 8'h34, 4'b1000, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 0, 3, 0, 8'h00, 4'b0000, 1));
    // master 1 single beat (ptr=1), then reset on beat 2 of master 2's burst
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 1, 8'h01, 0, 3, 0, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 1, 8'h01, 1, 1, 1, 8'h11, 4'b0010, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 1, 8'h01, 0, 1, 0, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 1, 8'h01, 1, 2, 1, 8'h21, 4'b0100, 0));
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 1, 8'h02, 1, 2, 1, 8'h22, 4'b0100, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'h07, 0, 0, 0, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'h07, 1, 0, 1, 8'h07, 4'b0001, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 0, 0, 0, 8'h00, 4'b0000, 0));
    // granted master drops ReqValid mid-grant: stays in BURST, DInValid low
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 1, 8'h01, 0, 0, 0, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h01, 1, 2, 0, 8'h21, 4'b0100, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, 8'h01, 1, 2, 1, 8'h21, 4'b0100, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 0, 2, 0, 8'h00, 4'b0000, 0));

    // reset state, with every master requesting while reset is held
    drive(1, 4'b1111, 4'b0000, 1, 8'h40);
    repeat (2) @(posedge Clk);
    @(negedge Clk); #1;
    chk("rst_busy", -1, 8'(bus.Busy), 8'h00);
    chk("rst_dinvalid", -1, 8'(bus.DInValid), 8'h00);
    chk("rst_din", -1, bus.DIn, 8'h00);
    chk("rst_reqready", -1, 8'(bus.ReqReady), 8'h00);
    chk("rst_trunc", -1, 8'(bus.BurstTrunc), 8'h00);
    chk("rst_grant", -1, 8'(bus.GrantIdx), 8'h00);

    foreach (tbl[n]) begin
      @(negedge Clk);
      drive(tbl[n].rst, tbl[n].v, tbl[n].l, tbl[n].rdy, tbl[n].d);
      #1;
      chk("busy", n, 8'(bus.Busy), 8'(tbl[n].busy));
      chk("grant", n, 8'(bus.GrantIdx), 8'(tbl[n].gi));
      chk("dinvalid", n, 8'(bus.DInValid), 8'(tbl[n].dv));
      chk("din", n, bus.DIn, tbl[n].din);
      chk("reqready", n, 8'(bus.ReqReady), 8'(tbl[n].rr));
      chk("trunc", n, 8'(bus.BurstTrunc), 8'(tbl[n].tr));
    end

    // random traffic: ReqReady only ever on the granted master, at most one bit
    for (int c = 0; c < 300; c++) begin
      logic rr_ok;
      @(negedge Clk);
      drive(($urandom_range(0, 49) == 0), 4'($urandom), 4'($urandom), 1'($urandom), 8'($urandom));
      #1;
      rr_ok = ($countones(bus.ReqReady) <= 1) &&
              ((bus.ReqReady & ~(4'b0001 << bus.GrantIdx)) == 4'b0000) &&
              (bus.Busy || bus.ReqReady == 4'b0000);
      chk("rr_onehot", c, 8'(rr_ok), 8'h01);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
